// File: rtl/icache_dm_if.sv
// rtl/icache_dm_if.sv - fetch, refill and counter signal bundle for icache_dm
interface icache_dm_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_data, mem_req_valid, mem_req_addr,
           hit_count, miss_count
  );
endinterface

// File: rtl/icache_dm.sv
// rtl/icache_dm.sv - direct-mapped instruction cache with line refill, flush and hit/miss counters
module icache_dm #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic       clk,
  input  logic       reset,
  icache_dm_if.slave bus
);
  localparam int OFF = $clog2(WORDS_PER_LINE);
  localparam int IDX = $clog2(LINES);
  localparam int TAG = 30 - OFF - IDX;

  typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;
  state_t state, state_next;

  logic [31:0]      data_arr [LINES*WORDS_PER_LINE];
  logic [TAG-1:0]   tag_arr  [LINES];
  logic [LINES-1:0] valid;

  logic [OFF-1:0] req_off;
  logic [IDX-1:0] req_idx;
  logic [TAG-1:0] req_tag;
  logic [OFF-1:0] lat_off;
  logic [IDX-1:0] lat_idx;
  logic [TAG-1:0] lat_tag;
  logic [OFF:0]   beat_cnt;
  logic [OFF-1:0] fill_cnt;
  logic           flush_pend;

  logic        resp_valid;
  logic [31:0] resp_data;
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        req_ready;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        accept;
  logic        hit;
  logic        fill_fire;
  logic        fill_last;

  assign req_off = bus.req_addr[1+OFF:2];
  assign req_idx = bus.req_addr[1+OFF+IDX:2+OFF];
  assign req_tag = bus.req_addr[31:2+OFF+IDX];

  always_comb begin
    state_next    = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'd0;
    accept        = 1'b0;
    fill_fire     = 1'b0;
    fill_last     = 1'b0;
    hit           = valid[req_idx] && (tag_arr[req_idx] == req_tag);
    case (state)
      IDLE: begin
        req_ready = !bus.flush;
        accept    = bus.req_valid && !bus.flush;
        if (accept && !hit) state_next = REFILL;
      end
      REFILL: begin
        // beat_cnt MSB set means every beat of the line has been handshaken
        mem_req_valid = !beat_cnt[OFF];
        if (mem_req_valid) mem_req_addr = {lat_tag, lat_idx, beat_cnt[OFF-1:0], 2'b00};
        fill_fire = bus.mem_resp_valid;
        fill_last = fill_fire && (fill_cnt == OFF'(WORDS_PER_LINE - 1));
        if (fill_last) state_next = RESPOND;
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid      <= '0;
      flush_pend <= 1'b0;
      beat_cnt   <= '0;
      fill_cnt   <= '0;
      lat_off    <= '0;
      lat_idx    <= '0;
      lat_tag    <= '0;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      state      <= state_next;
      resp_valid <= 1'b0;
      resp_data  <= 32'd0;
      if (accept && hit) begin
        resp_valid <= 1'b1;
        resp_data  <= data_arr[{req_idx, req_off}];
        hit_count  <= hit_count + 32'd1;
      end
      if (accept && !hit) begin
        lat_off    <= req_off;
        lat_idx    <= req_idx;
        lat_tag    <= req_tag;
        beat_cnt   <= '0;
        fill_cnt   <= '0;
        miss_count <= miss_count + 32'd1;
      end
      if (mem_req_valid && bus.mem_req_ready) beat_cnt <= beat_cnt + 1'b1;
      if (fill_fire) fill_cnt <= fill_cnt + 1'b1;
      if (fill_last) begin
        valid[lat_idx] <= 1'b1;
        resp_valid     <= 1'b1;
        // the requested word may be the beat arriving this very cycle
        resp_data      <= (fill_cnt == lat_off) ? bus.mem_resp_data : data_arr[{lat_idx, lat_off}];
      end
      if (state == IDLE && bus.flush) valid <= '0;
      if (state != IDLE && bus.flush) flush_pend <= 1'b1;
      if (state == RESPOND && (flush_pend || bus.flush)) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && fill_fire) data_arr[{lat_idx, fill_cnt}] <= bus.mem_resp_data;
    if (!reset && fill_last) tag_arr[lat_idx] <= lat_tag;
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_data     = resp_data;
  assign bus.mem_req_valid = mem_req_valid;
  assign bus.mem_req_addr  = mem_req_addr;
  assign bus.hit_count     = hit_count;
  assign bus.miss_count    = miss_count;
endmodule
